// File: rtl/regbank_port_arbiter.sv
// Arbitrates the register bank access slot among NUM_REQ requesters and returns 1-cycle read data.
// Round-robin by default; define RBARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module regbank_port_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 3,
   parameter int DW      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*AW-1:0] req_raddr_a,
   input  logic [NUM_REQ*AW-1:0] req_raddr_b,
   input  logic [NUM_REQ*AW-1:0] req_waddr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_rdata_a,
   output logic [DW-1:0]         rsp_rdata_b,
   output logic [AW-1:0]         rb_read_reg1,
   output logic [AW-1:0]         rb_read_reg2,
   output logic [AW-1:0]         rb_write_reg,
   output logic [DW-1:0]         rb_write_data,
   output logic                  rb_reg_write,
   input  logic [DW-1:0]         rb_read_data1,
   input  logic [DW-1:0]         rb_read_data2,
   output logic                  busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [AW-1:0] raddr_a_arr [NUM_REQ];
   logic [AW-1:0] raddr_b_arr [NUM_REQ];
   logic [AW-1:0] waddr_arr   [NUM_REQ];
   logic [DW-1:0] wdata_arr   [NUM_REQ];

   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          pending_reg;
   logic [IW-1:0] pend_idx_reg;
   logic          rsp_active;

   // A response still in flight when reset arrives is dropped in that same cycle.
   assign rsp_active = pending_reg && !reset;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign raddr_a_arr[gi] = req_raddr_a[gi*AW +: AW];
         assign raddr_b_arr[gi] = req_raddr_b[gi*AW +: AW];
         assign waddr_arr[gi]   = req_waddr[gi*AW +: AW];
         assign wdata_arr[gi]   = req_wdata[gi*DW +: DW];
         assign req_ready[gi]   = grant_valid && (grant_idx == IW'(gi));
         assign rsp_valid[gi]   = rsp_active && (pend_idx_reg == IW'(gi));
      end
   endgenerate

`ifdef RBARB_FIXED_PRIO_EN
   // Descending scan so the lowest valid index is the last (winning) assignment.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(k);
         end
      end
      if (reset) grant_valid = 1'b0;
   end
`else
   logic [IW-1:0] rr_ptr_reg;
   logic [IW-1:0] rr_ptr_next;
   logic [IW:0]   cand;

   // Scan offsets from NUM_REQ down to 1 so the candidate closest after rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
         if (req_valid[cand[IW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IW-1:0];
         end
      end
      if (reset) grant_valid = 1'b0;
   end

   assign rr_ptr_next = grant_valid ? grant_idx : rr_ptr_reg;

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_reg <= IW'(NUM_REQ - 1);
      else       rr_ptr_reg <= rr_ptr_next;
   end
`endif

   assign rb_read_reg1  = grant_valid ? raddr_a_arr[grant_idx] : '0;
   assign rb_read_reg2  = grant_valid ? raddr_b_arr[grant_idx] : '0;
   assign rb_write_reg  = grant_valid ? waddr_arr[grant_idx]   : '0;
   assign rb_write_data = grant_valid ? wdata_arr[grant_idx]   : '0;
   assign rb_reg_write  = grant_valid && req_we[grant_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg  <= 1'b0;
         pend_idx_reg <= '0;
      end else begin
         pending_reg <= grant_valid;
         if (grant_valid) pend_idx_reg <= grant_idx;
      end
   end

   // The bank registers its read data, so it lines up with the pending response.
   assign rsp_rdata_a = rb_read_data1;
   assign rsp_rdata_b = rb_read_data2;

   assign busy = !reset && (pending_reg || (|req_valid));

endmodule

// File: doc/regbank_port_arbiter.md
Name: regbank_port_arbiter

Overview:
- Shares the single access slot of the 8x32 register bank among NUM_REQ requesters.
- Per slot, the bank provides two synchronous read ports and one write port.
- Arbitration is round-robin, one granted access per cycle.
- The block drives the bank's address, write-data and write-enable inputs, then routes the 1-cycle-latency read data back to the granted requester with a response strobe.
- It sits between pipeline/DMA/debug masters and the register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 3, register address width (8 registers)
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  grant/accept, one-hot or zero
- req_we  in  NUM_REQ  request includes a write
- req_raddr_a  in  NUM_REQ*AW  operand A read address, packed (requester i at [i*AW +: AW])
- req_raddr_b  in  NUM_REQ*AW  operand B read address, packed
- req_waddr  in  NUM_REQ*AW  write address, packed
- req_wdata  in  NUM_REQ*DW  write data, packed
- rsp_valid  out  NUM_REQ  read response strobe, one-hot or zero
- rsp_rdata_a  out  DW  operand A data, valid when any rsp_valid bit is high
- rsp_rdata_b  out  DW  operand B data
- rb_read_reg1  out  AW  to bank read port 1
- rb_read_reg2  out  AW  to bank read port 2
- rb_write_reg  out  AW  to bank write address
- rb_write_data  out  DW  to bank write data
- rb_reg_write  out  1  to bank write enable
- rb_read_data1  in  DW  from bank, registered one cycle after address
- rb_read_data2  in  DW  from bank
- busy  out  1  response pending or any request valid

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- **Reset values:**
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
  - rsp_valid = 0, pending flag = 0, pending index = 0.
  - rb_reg_write = 0.
  - rb_* addresses and data = 0.
  - busy = 0.
- **Arbitration (combinational in cycle t):**
  - Search req_valid starting at index rr_ptr+1 and wrapping modulo NUM_REQ.
  - The first set bit is granted, and req_ready for that bit is asserted.
  - If no request is valid, req_ready = 0 and rb_reg_write = 0.
- **Handshake:**
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - The requester holds valid and all fields stable until the transfer.
  - req_ready never depends on the requester's own deassertion.
  - Throughput is one access per cycle.
- **Bank drive on grant of requester g:**
  - rb_read_reg1 = raddr_a[g].
  - rb_read_reg2 = raddr_b[g].
  - rb_write_reg = waddr[g].
  - rb_write_data = wdata[g].
  - rb_reg_write = req_we[g].
  - These outputs are combinational from the grant. With no grant, they hold 0.
- **State update at the edge ending cycle t, if a grant occurred:**
  - rr_ptr <= g.
  - pending <= 1.
  - pend_idx <= g.
  - Otherwise pending <= 0 and rr_ptr holds.
- **Response in cycle t+1:**
  - rsp_valid[pend_idx] = pending.
  - rsp_rdata_a = rb_read_data1 and rsp_rdata_b = rb_read_data2, passed through.
  - Data is sampled by the bank at the same edge as the write, so reads see the pre-write value, including when read and write addresses are equal.
  - A read granted in cycle t+1 sees a write granted in cycle t.
- **Every grant produces exactly one response**, including write-only requests; requesters may ignore it.
- **Back-to-back grants:** responses follow one per cycle in grant order. There is no buffering; requesters must accept responses (no rsp_ready).
- **Wrap-around:**
  - rr_ptr = NUM_REQ-1 makes index 0 the next candidate.
  - A single active requester is granted every cycle.
- **Reset mid-operation:**
  - A grant in the reset cycle is suppressed (req_ready = 0, rb_reg_write = 0).
  - A pending response is dropped: rsp_valid = 0 in the cycle after reset.

Optional Feature:
- Macro RBARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. rr_ptr is removed and every other behaviour is unchanged.
- When undefined: round-robin as specified above.

Test Plan:
- **Single write, then read:** requester 1 writes reg 5 = 0xDEADBEEF in cycle 0 (req_ready[1] = 1, rb_reg_write = 1). Requester 1 reads a=5, b=5 in cycle 1. Required: rsp_valid[1] in cycle 2, rsp_rdata_a = rsp_rdata_b = 0xDEADBEEF.
- **Round-robin fairness:** all 4 requesters hold valid for 8 cycles from reset. Required: grants 0,1,2,3,0,1,2,3, and responses to 0,1,2,3,0,1,2,3 one cycle later.
- **Same-cycle hazard:** requester 2 writes reg 3 = 0x11 while reading a=3, with reg 3 previously 0x22. Required: rsp_rdata_a = 0x22 next cycle.
- **Sparse wrap:** only requesters 3 and 0 valid after requester 3 was last granted. Required: grant 0, then 3, then 0.
- **Reset mid-operation:** grant requester 1 in cycle t, assert reset in cycle t+1. Required: rsp_valid = 0 in t+1 and t+2, req_ready = 0 during reset, and after reset requester 0 is granted first.
- **With RBARB_FIXED_PRIO_EN:** requesters 0 and 2 continuously valid for 4 cycles. Required: requester 0 granted every cycle, requester 2 never.
